// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - command and response handshake bundle for alu_cmd_driver
interface alu_cmd_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_acc;
    logic       rsp_cy;
    logic       rsp_z;

    // Command source / response consumer side
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_b,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_acc,
        input  rsp_cy,
        input  rsp_z
    );

    // Sequencer side
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_b,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_acc,
        output rsp_cy,
        output rsp_z
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - accumulator sequencer driving a 4-bit ALU from a command stream
module alu_cmd_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_cmd_driver_if.slave  bus,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [4:0]       alu_out,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_CLEAR = 4'b1001;

    state_t           state_q,     state_d;
    logic [3:0]       acc_q,       acc_d;
    logic [3:0]       op_q,        op_d;
    logic [3:0]       b_q,         b_d;
    logic [3:0]       alu_a_q,     alu_a_d;
    logic [3:0]       alu_b_q,     alu_b_d;
    logic [2:0]       alu_sel_q,   alu_sel_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [3:0]       rsp_acc_q,   rsp_acc_d;
    logic             rsp_cy_q,    rsp_cy_d;
    logic             rsp_z_q,     rsp_z_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    logic [3:0]       exec_acc;
    logic             exec_cy;

    // Result of the latched command: ALU ops take the low nibble, only the
    // arithmetic half (sel[2]=0) reports alu_out[4] as carry/borrow
    always_comb begin
        exec_acc = acc_q;
        exec_cy  = 1'b0;
        if (!op_q[3]) begin
            exec_acc = alu_out[3:0];
            exec_cy  = ~op_q[2] & alu_out[4];
        end else if (op_q == OP_LOAD) begin
            exec_acc = b_q;
        end else if (op_q == OP_CLEAR) begin
            exec_acc = 4'h0;
        end
    end

    // Next-state and registered-output logic for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        b_d         = b_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_acc_d   = rsp_acc_q;
        rsp_cy_d    = rsp_cy_q;
        rsp_z_d     = rsp_z_q;
        op_count_d  = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d        = bus.cmd_op;
                    b_d         = bus.cmd_b;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_EXEC;
                    // ALU inputs only move for real ALU ops; otherwise they keep
                    // the last issued values so the ALU output stays quiet
                    if (!bus.cmd_op[3]) begin
                        alu_a_d   = acc_q;
                        alu_b_d   = bus.cmd_b;
                        alu_sel_d = bus.cmd_op[2:0];
                    end
                end
            end
            ST_EXEC: begin
                acc_d       = exec_acc;
                rsp_acc_d   = exec_acc;
                rsp_cy_d    = exec_cy;
                rsp_z_d     = (exec_acc == 4'h0);
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any command in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= 4'h0;
            op_q        <= 4'h0;
            b_q         <= 4'h0;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            alu_sel_q   <= 3'b000;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_acc_q   <= 4'h0;
            rsp_cy_q    <= 1'b0;
            rsp_z_q     <= 1'b1;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            b_q         <= b_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_acc_q   <= rsp_acc_d;
            rsp_cy_q    <= rsp_cy_d;
            rsp_z_q     <= rsp_z_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_acc   = rsp_acc_q;
    assign bus.rsp_cy    = rsp_cy_q;
    assign bus.rsp_z     = rsp_z_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sel       = alu_sel_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with an ALU stand-in
module tb_alu_cmd_driver;
    localparam int TB_CNT_W = 2;
    localparam int CNT_MOD  = 1 << TB_CNT_W;

    logic                clk;
    logic                rst_n;
    logic [3:0]          alu_a;
    logic [3:0]          alu_b;
    logic [2:0]          alu_sel;
    logic [4:0]          alu_out;
    logic [TB_CNT_W-1:0] op_count;

    alu_cmd_driver_if bus ();

    alu_cmd_driver #(.CNT_W(TB_CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .op_count (op_count)
    );

    // ALU stand-in: add, inc, sub, dec, and, nand (zero-extended invert), or, xor
    always_comb begin
        case (alu_sel)
            3'b000:  alu_out = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  alu_out = {1'b0, alu_a} + 5'd1;
            3'b010:  alu_out = {1'b0, alu_a} - {1'b0, alu_b};
            3'b011:  alu_out = {1'b0, alu_a} - 5'd1;
            3'b100:  alu_out = {1'b0, alu_a & alu_b};
            3'b101:  alu_out = ~{1'b0, alu_a & alu_b};
            3'b110:  alu_out = {1'b0, alu_a | alu_b};
            default: alu_out = {1'b0, alu_a ^ alu_b};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_m  = 0;
    int cnt_m  = 0;
    int exp_acc;
    int exp_cy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the accumulator, carry when the sum
    // exceeds 15, borrow when the difference goes negative
    task automatic model_cmd(input logic [3:0] op, input logic [3:0] b);
        int o, v, r;
        o = int'(op);
        v = int'(b);
        r = acc_m;
        exp_cy = 0;
        case (o)
            0: begin r = acc_m + v;  exp_cy = (r > 15) ? 1 : 0; end
            1: begin r = acc_m + 1;  exp_cy = (r > 15) ? 1 : 0; end
            2: begin r = acc_m - v;  exp_cy = (r < 0) ? 1 : 0;  end
            3: begin r = acc_m - 1;  exp_cy = (r < 0) ? 1 : 0;  end
            4: r = acc_m & v;
            5: r = 15 - (acc_m & v);
            6: r = acc_m | v;
            7: r = acc_m ^ v;
            8: r = v;
            9: r = 0;
            default: r = acc_m;
        endcase
        acc_m   = (r + 16) % 16;
        exp_acc = acc_m;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge inside EXEC
    task automatic send(input logic [3:0] op, input logic [3:0] b);
        int n;
        int pre_acc;
        bus.cmd_op    = op;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        pre_acc = acc_m;
        model_cmd(op, b);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("exec_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        if (!op[3]) begin
            chk("exec_alu_a", 32'(alu_a), 32'(pre_acc));
            chk("exec_alu_b", 32'(alu_b), 32'(b));
            chk("exec_alu_sel", 32'(alu_sel), 32'(op[2:0]));
        end
    endtask

    // Waits for the response, optionally stalls it while offering a stray command
    task automatic recv(input int hold);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 32'(n < 20), 32'd1);
        chk("rsp_acc", 32'(bus.rsp_acc), 32'(exp_acc));
        chk("rsp_cy", 32'(bus.rsp_cy), 32'(exp_cy));
        chk("rsp_z", 32'(bus.rsp_z), 32'(exp_acc == 0));
        chk("rsp_op_count", 32'(op_count), 32'(cnt_m % CNT_MOD));
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 4'b1000;
            bus.cmd_b     = 4'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_acc", 32'(bus.rsp_acc), 32'(exp_acc));
            chk("hold_cy", 32'(bus.rsp_cy), 32'(exp_cy));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        cnt_m++;
        chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("done_op_count", 32'(op_count), 32'(cnt_m % CNT_MOD));
        chk("done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    // Random back-to-back commands with the consumer always ready
    task automatic run_stream(input int n_ops);
        int issued;
        int got;
        int last_cyc;
        bit adv;
        int qa[$];
        int qc[$];
        int ea;
        int ec;
        issued   = 0;
        got      = 0;
        last_cyc = 0;
        adv      = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'($urandom);
        bus.cmd_b     = 4'($urandom);
        for (int cyc = 0; cyc < n_ops * 3 + 20 && got < n_ops; cyc++) begin
            if (adv) begin
                adv = 1'b0;
                if (issued == n_ops) bus.cmd_valid = 1'b0;
                else begin
                    bus.cmd_op = 4'($urandom);
                    bus.cmd_b  = 4'($urandom);
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                chk("stream_expected", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    ec = qc.pop_front();
                    chk("stream_acc", 32'(bus.rsp_acc), 32'(ea));
                    chk("stream_cy", 32'(bus.rsp_cy), 32'(ec));
                    chk("stream_z", 32'(bus.rsp_z), 32'(ea == 0));
                end
                if (got > 0) chk("stream_spacing", 32'(cyc - last_cyc), 32'd3);
                chk("stream_op_count", 32'(op_count), 32'(cnt_m % CNT_MOD));
                last_cyc = cyc;
                cnt_m++;
                got++;
            end
            if (bus.cmd_valid && bus.cmd_ready === 1'b1) begin
                model_cmd(bus.cmd_op, bus.cmd_b);
                qa.push_back(exp_acc);
                qc.push_back(exp_cy);
                issued++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        chk("stream_count", 32'(got), 32'(n_ops));
        chk("stream_final_count", 32'(op_count), 32'(cnt_m % CNT_MOD));
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_b     = 4'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_acc", 32'(bus.rsp_acc), 32'd0);
        chk("reset_rsp_cy", 32'(bus.rsp_cy), 32'd0);
        chk("reset_rsp_z", 32'(bus.rsp_z), 32'd1);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_sel", 32'(alu_sel), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Increment wraps 0xF to 0 with carry
        send(4'b1000, 4'hF); recv(0);
        send(4'b0001, 4'h0); recv(0);
        // Subtract underflow borrows
        send(4'b1000, 4'h3); recv(0);
        send(4'b0010, 4'h5); recv(0);
        // NAND bit4 must not reach carry
        send(4'b1000, 4'hF); recv(0);
        send(4'b0101, 4'hF); recv(0);
        // Backpressure with a stray command offered during RESP
        send(4'b1000, 4'h6); recv(5);
        send(4'b1010, 4'h0); recv(0);
        send(4'b1001, 4'h0); recv(0);

        // Reset while a command is executing
        send(4'b1000, 4'h7); recv(0);
        send(4'b0000, 4'h3);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = 0;
        cnt_m = 0;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_rsp_acc", 32'(bus.rsp_acc), 32'd0);
        chk("abort_rsp_z", 32'(bus.rsp_z), 32'd1);
        chk("abort_op_count", 32'(op_count), 32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        send(4'b1010, 4'h0); recv(0);

        run_stream(5);
        run_stream(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
